// File: rtl/exu_shift_pkg.sv
// Shared types and op-encoding helpers for the execute-stage shift arbiter.
// The five legal {mode1,mode2} codes are the only ones forwarded to the shift unit.
package exu_shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sh_state_e;

   // {mode1, mode2}
   localparam logic [4:0] SH_SLL  = 5'b00_000;
   localparam logic [4:0] SH_SRL  = 5'b00_010;
   localparam logic [4:0] SH_SRA  = 5'b00_100;
   localparam logic [4:0] SH_SLLI = 5'b10_000;
   localparam logic [4:0] SH_SRLI = 5'b10_010;

   function automatic logic sh_legal(input logic [1:0] mode1, input logic [2:0] mode2);
      case ({mode1, mode2})
         SH_SLL, SH_SRL, SH_SRA, SH_SLLI, SH_SRLI: sh_legal = 1'b1;
         default:                                  sh_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Kept generic so other shared execute units can reuse it.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end

endmodule

// File: rtl/exu_shift_arb.sv
// Shares the single shift unit between NUM_REQ requesters: one op in flight,
// round-robin grant, bounded wait for su_done, backpressured response.
module exu_shift_arb
   import exu_shift_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 32,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*XLEN-1:0]    req_op1,
   input  logic [NUM_REQ*XLEN-1:0]    req_op2,
   input  logic [NUM_REQ*2-1:0]       req_mode1,
   input  logic [NUM_REQ*3-1:0]       req_mode2,
   input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
   output logic                       su_start,
   output logic [XLEN-1:0]            su_op1,
   output logic [XLEN-1:0]            su_op2,
   output logic [1:0]                 su_mode1,
   output logic [2:0]                 su_mode2,
   input  logic                       su_done,
   input  logic [XLEN-1:0]            su_res,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [TAG_W-1:0]           rsp_tag,
   output logic [XLEN-1:0]            rsp_res,
   output logic                       rsp_err
);

   localparam int IW  = $clog2(NUM_REQ);
   localparam int WCW = $clog2(TIMEOUT + 1);

   logic [NUM_REQ-1:0][XLEN-1:0]  op1_a, op2_a;
   logic [NUM_REQ-1:0][1:0]       m1_a;
   logic [NUM_REQ-1:0][2:0]       m2_a;
   logic [NUM_REQ-1:0][TAG_W-1:0] tag_a;

   assign op1_a = req_op1;
   assign op2_a = req_op2;
   assign m1_a  = req_mode1;
   assign m2_a  = req_mode2;
   assign tag_a = req_tag;

   sh_state_e        state, state_nxt;
   logic [IW-1:0]    rr_ptr;
   logic [WCW-1:0]   wait_cnt;
   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;
   logic             sel_legal;
   logic             wait_expired;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (gnt),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   assign sel_legal    = sh_legal(m1_a[gnt_idx], m2_a[gnt_idx]);
   assign wait_expired = (wait_cnt == WCW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (gnt_any) state_nxt = sel_legal ? ISSUE : RESP;
         ISSUE: state_nxt = WAIT;
         WAIT:  if (su_done || wait_expired) state_nxt = RESP;
         RESP:  if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE) ? gnt : '0;
      su_start  = (state == ISSUE);
      rsp_valid = (state == RESP);
   end

   // Operand/response registers; su_* hold from accept through WAIT, rsp_* through RESP.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr   <= '0;
         wait_cnt <= '0;
         su_op1   <= '0;
         su_op2   <= '0;
         su_mode1 <= '0;
         su_mode2 <= '0;
         rsp_id   <= '0;
         rsp_tag  <= '0;
         rsp_res  <= '0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (gnt_any) begin
               su_op1   <= op1_a[gnt_idx];
               su_op2   <= op2_a[gnt_idx];
               su_mode1 <= m1_a[gnt_idx];
               su_mode2 <= m2_a[gnt_idx];
               rsp_id   <= gnt_idx;
               rsp_tag  <= tag_a[gnt_idx];
               rsp_res  <= '0;
               rsp_err  <= ~sel_legal;
            end
            ISSUE: wait_cnt <= '0;
            WAIT: begin
               if (su_done) begin
                  rsp_res <= su_res;
                  rsp_err <= 1'b0;
               end else if (wait_expired) begin
                  rsp_res <= '0;
                  rsp_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: if (rsp_ready)
               rr_ptr <= (rsp_id == IW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/exu_shift_arb.md
Name: exu_shift_arb

Overview:
- Round-robin arbiter and sequencer that shares the single shift unit of the RV052B execute stage between NUM_REQ requesters, e.g. two issue slots.
- Accepts one shift request at a time, checks the op encoding, and drives the shift unit's one-cycle start/done handshake.
- Captures the result, bounds the wait with a timeout, and returns result, tag and source id over a backpressured response port.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- XLEN, 32: operand/result width.
- TAG_W, 4: width of the opaque requester tag returned with each result.
- TIMEOUT, 15: maximum cycles spent in WAIT before an error response; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_op1  in  NUM_REQ*XLEN  rs1 operand, slot i at [i*XLEN +: XLEN]
- req_op2  in  NUM_REQ*XLEN  shift amount; only bits [4:0] are meaningful
- req_mode1  in  NUM_REQ*2  op_mode1 per slot
- req_mode2  in  NUM_REQ*3  op_mode2 per slot
- req_tag  in  NUM_REQ*TAG_W  requester tag
- su_start  out  1  one-cycle start pulse to the shift unit
- su_op1  out  XLEN  latched operand 1
- su_op2  out  XLEN  latched operand 2
- su_mode1  out  2  latched mode1
- su_mode2  out  3  latched mode2
- su_done  in  1  shift unit done, high the cycle after start is sampled
- su_res  in  XLEN  shift result, valid only while su_done=1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  clog2(NUM_REQ)  granted requester index
- rsp_tag  out  TAG_W  echoed tag
- rsp_res  out  XLEN  result; 0 on error
- rsp_err  out  1  1 = illegal encoding or timeout

Behaviour:
- Clock and reset: clk, rising edge. Reset rst is synchronous, active-low (rst=0 resets).
- Reset values: state=IDLE, rr_ptr=0, wait_cnt=0, all outputs 0.
- A reset in any state, including mid-WAIT, aborts the operation silently; a late su_done afterwards is ignored.
- IDLE:
  - Grant the lowest index ≥ rr_ptr (cyclic) with req_valid=1.
  - Assert req_ready for the granted slot combinationally in the same cycle.
  - On the edge, latch op1/op2/mode1/mode2/tag/id.
  - Legal encoding (see table below) → ISSUE. Illegal → RESP with rsp_err=1, rsp_res=0.
  - No valid requests → stay in IDLE, req_ready=0.
- ISSUE: su_start=1 for exactly one cycle; su_* operands are stable from here through WAIT; wait_cnt cleared → WAIT.
- WAIT:
  - su_done=1 → rsp_res<=su_res, rsp_err<=0 → RESP.
  - Else wait_cnt++. When wait_cnt reaches TIMEOUT → rsp_err<=1, rsp_res<=0 → RESP.
  - su_done is sampled only in WAIT.
- RESP:
  - rsp_valid=1; rsp_id/tag/res/err are held stable until rsp_ready=1.
  - On the handshake edge: rr_ptr<=(id+1) mod NUM_REQ, → IDLE.
- Throughput and latency:
  - At most one request in flight; req_ready=0 in ISSUE/WAIT/RESP.
  - Legal op, no backpressure: accept edge T0, su_start during T1, su_done during T2, rsp_valid from T3. Next accept no earlier than the cycle after the handshake.
- Fairness: a requester that drops req_valid before being granted is not remembered. Round-robin guarantees every continuously asserted requester is granted within NUM_REQ grants.
- Legal {mode1,mode2} set:
  - SLL 00/000
  - SRL 00/010
  - SRA 00/100
  - SLLI 10/000
  - SRLI 10/010
- Operands pass through unmodified; no width or sign manipulation is done here.

Decomposition:
- Package exu_shift_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, RESP
  - mode constants: SH_SLL, SH_SRL, SH_SRA, SH_SLLI, SH_SRLI as {mode1,mode2} 5-bit codes
  - function sh_legal(mode1, mode2)
- Sub-module rr_arbiter (inputs req vector and rr_ptr, output one-hot grant plus index), combinational and reusable by the future mul/div arbiter.

Test Plan:
- Single request, slot0 SLL op1=0x0000_0001, op2=4, tag=3, rsp_ready=1 → su_start pulses at T1; rsp_valid at T3 with rsp_res=0x10, id=0, tag=3, err=0.
- Slots 0 and 1 both valid continuously for 4 requests → grant order 0,1,0,1; no back-to-back grant to the same slot.
- Illegal encoding mode1=01, mode2=000 → su_start never asserts; rsp_valid the cycle after accept with err=1, res=0.
- su_done stuck 0, TIMEOUT=15 → rsp_valid with err=1 exactly 16 cycles after entering WAIT; arbiter returns to IDLE after the handshake.
- rsp_ready held 0 for 5 cycles → rsp_* stable throughout and req_ready=0 on all slots; handshake on cycle 6 → IDLE; the next pending slot is granted.
- rst=0 during WAIT, su_done=1 the next cycle → no rsp_valid, all outputs 0, rr_ptr=0; a new request afterwards completes normally.
